upd7800_clkgen: RTL and testbench



---
 rtl/upd7800_clkgen_if.sv | 26 ++
 rtl/upd7800_clkgen.sv | 98 +++++++++
 tb/tb_upd7800_clkgen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/upd7800_clkgen_if.sv
// Bus between the uPD7800 clock/reset generator and the core.
// The generator owns the phase strobes, levels, HOLDA and RESETB.
// The memory/cartridge side owns HOLD.
interface upd7800_clkgen_if;
  logic HOLD;
  logic CP1_POSEDGE;
  logic CP1_NEGEDGE;
  logic CP2_POSEDGE;
  logic CP2_NEGEDGE;
  logic CP1;
  logic CP2;
  logic HOLDA;
  logic RESETB;

  modport master (
    input  HOLD,
    output CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE,
    output CP1, CP2, HOLDA, RESETB
  );

  modport slave (
    output HOLD,
    input  CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE,
    input  CP1, CP2, HOLDA, RESETB
  );
endinterface

// File: rtl/upd7800_clkgen.sv
// Clock-phase sequencer and reset stretcher for the uPD7800 core.
// A T-state is four quarters (Q0..Q3), each DIV clocks long. A one-clock
// strobe is issued in the first clock of every quarter.
// HOLD freezes the sequence at the T-state boundary, which is the Q0 entry.
// RESETB is held low until RST_TSTATES CP2 falling edges have been issued.
module upd7800_clkgen #(
  parameter int unsigned DIV         = 1,   // clocks per quarter, 1..16
  parameter int unsigned RST_TSTATES = 4    // T-states of RESETB extension, 1..255
) (
  input  logic            CLK,
  input  logic            RESET,
  upd7800_clkgen_if.master bus
);

  localparam int unsigned    QW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0]  QMAX    = QW'(DIV - 1);
  localparam logic [7:0]     EXT_MAX = 8'(RST_TSTATES);

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  quarter_t      phase, phase_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic          run, run_nxt;          // 0 for the cycle after RESET is sampled
  logic [7:0]    ext_cnt, ext_cnt_nxt;  // CP2 falling edges seen since reset

  logic first;     // first clock of the current quarter
  logic boundary;  // this cycle would start a new T-state
  logic frozen;    // boundary reached with HOLD requested
  logic cp2n;

  // State register: the reset state sits at the end of Q3, so the sequence
  // restarts at Q0 once RESET is released.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RESET) begin
      phase   <= Q3;
      qcnt    <= '0;
      run     <= 1'b0;
      ext_cnt <= '0;
    end else begin
      phase   <= phase_nxt;
      qcnt    <= qcnt_nxt;
      run     <= run_nxt;
      ext_cnt <= ext_cnt_nxt;
    end
  end

  // Output decode and next-state logic. HOLD reaches the outputs only
  // through the boundary gating of CP1_POSEDGE, CP1 and HOLDA.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned and no latch is inferred.
    phase_nxt   = phase;
    qcnt_nxt    = qcnt;
    run_nxt     = run;
    ext_cnt_nxt = ext_cnt;

    first    = (qcnt == '0);
    boundary = run && (phase == Q0) && first;
    frozen   = boundary && bus.HOLD;
    cp2n     = run && (phase == Q3) && first;

    bus.CP1_POSEDGE = boundary && !bus.HOLD;
    bus.CP1_NEGEDGE = run && (phase == Q1) && first;
    bus.CP2_POSEDGE = run && (phase == Q2) && first;
    bus.CP2_NEGEDGE = cp2n;
    bus.CP1         = run && (phase == Q0) && !frozen;
    bus.CP2         = run && (phase == Q2);
    bus.HOLDA       = frozen;
    bus.RESETB      = (ext_cnt == EXT_MAX);

    if (!run) begin
      // Leaving reset: the first cycle after this one is the Q0 boundary.
      run_nxt  = 1'b1;
      phase_nxt = Q0;
      qcnt_nxt  = '0;
    end else if (!frozen) begin
      if (qcnt == QMAX) begin
        qcnt_nxt = '0;
        unique case (phase)
          Q0: phase_nxt = Q1;
          Q1: phase_nxt = Q2;
          Q2: phase_nxt = Q3;
          Q3: phase_nxt = Q0;
        endcase
      end else begin
        qcnt_nxt = qcnt + 1'b1;
      end
    end

    // Reset extension counts completed T-states and saturates.
    if (cp2n && (ext_cnt != EXT_MAX)) begin
      ext_cnt_nxt = ext_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_upd7800_clkgen.sv
// Directed bench for upd7800_clkgen: four instances (DIV=1/RST=4, DIV=3,
// DIV=1/RST=2, DIV=16) driven one scenario at a time. Cycle n is the clock
// period that starts at posedge n; cycle 0 is the last one whose starting
// edge samples RESET high. Inputs change 1ns after the edge, and outputs
// are sampled on the falling edge.
module tb_upd7800_clkgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v  [4];
  logic hold_v [4];

  upd7800_clkgen_if if_a();
  upd7800_clkgen_if if_b();
  upd7800_clkgen_if if_c();
  upd7800_clkgen_if if_d();

  assign if_a.HOLD = hold_v[0];
  assign if_b.HOLD = hold_v[1];
  assign if_c.HOLD = hold_v[2];
  assign if_d.HOLD = hold_v[3];

  upd7800_clkgen #(.DIV(1),  .RST_TSTATES(4)) dut_a (.CLK(clk), .RESET(rst_v[0]), .bus(if_a.master));
  upd7800_clkgen #(.DIV(3),  .RST_TSTATES(4)) dut_b (.CLK(clk), .RESET(rst_v[1]), .bus(if_b.master));
  upd7800_clkgen #(.DIV(1),  .RST_TSTATES(2)) dut_c (.CLK(clk), .RESET(rst_v[2]), .bus(if_c.master));
  upd7800_clkgen #(.DIV(16), .RST_TSTATES(4)) dut_d (.CLK(clk), .RESET(rst_v[3]), .bus(if_d.master));

  // {CP1P, CP1N, CP2P, CP2N, CP1, CP2, HOLDA, RESETB}
  logic [7:0] outs [4];
  assign outs[0] = {if_a.CP1_POSEDGE, if_a.CP1_NEGEDGE, if_a.CP2_POSEDGE, if_a.CP2_NEGEDGE,
                    if_a.CP1, if_a.CP2, if_a.HOLDA, if_a.RESETB};
  assign outs[1] = {if_b.CP1_POSEDGE, if_b.CP1_NEGEDGE, if_b.CP2_POSEDGE, if_b.CP2_NEGEDGE,
                    if_b.CP1, if_b.CP2, if_b.HOLDA, if_b.RESETB};
  assign outs[2] = {if_c.CP1_POSEDGE, if_c.CP1_NEGEDGE, if_c.CP2_POSEDGE, if_c.CP2_NEGEDGE,
                    if_c.CP1, if_c.CP2, if_c.HOLDA, if_c.RESETB};
  assign outs[3] = {if_d.CP1_POSEDGE, if_d.CP1_NEGEDGE, if_d.CP2_POSEDGE, if_d.CP2_NEGEDGE,
                    if_d.CP1, if_d.CP2, if_d.HOLDA, if_d.RESETB};

  localparam logic [7:0] Z   = 8'b0000_0000;
  localparam logic [7:0] C1P = 8'b1000_1000;  // CP1 rises, CP1 level high
  localparam logic [7:0] C1N = 8'b0100_0000;
  localparam logic [7:0] C2P = 8'b0010_0100;  // CP2 rises, CP2 level high
  localparam logic [7:0] C2N = 8'b0001_0000;
  localparam logic [7:0] L1  = 8'b0000_1000;  // CP1 level only
  localparam logic [7:0] L2  = 8'b0000_0100;  // CP2 level only
  localparam logic [7:0] HA  = 8'b0000_0010;
  localparam logic [7:0] RB  = 8'b0000_0001;

  typedef struct {
    int         scn;
    int         cyc;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input int scn, input int cyc, input logic [7:0] exp);
    vec_t v;
    v.scn = scn;
    v.cyc = cyc;
    v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Reset instance `sel`, then run cycles 0..ncyc with HOLD high over
  // [hlo,hhi] and a one-cycle RESET pulse driven in cycle rpulse.
  task automatic run_scn(input int scn, input int sel, input int ncyc,
                         input int hlo, input int hhi, input int rpulse);
    logic [7:0] o;
    @(posedge clk); #1;
    rst_v[sel]  = 1'b1;
    hold_v[sel] = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c <= ncyc; c++) begin
      @(posedge clk); #1;
      rst_v[sel]  = (c == rpulse);
      hold_v[sel] = (c >= hlo) && (c <= hhi);
      @(negedge clk);
      o = outs[sel];
      check($sformatf("s%0d cp1_cp2_overlap_or_multi_strobe", scn), c,
            {6'd0, o[3] & o[2], ($countones(o[7:4]) > 1)}, 8'd0);
      foreach (tbl[i]) begin
        if (tbl[i].scn == scn && tbl[i].cyc == c) begin
          check($sformatf("s%0d outputs", scn), c, o, tbl[i].exp);
        end
      end
    end
    @(posedge clk); #1;
    rst_v[sel]  = 1'b1;
    hold_v[sel] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i]  = 1'b1;
      hold_v[i] = 1'b0;
    end

    // 1: DIV=1 sequence, RESETB at 17, then a RESET pulse in cycle 30.
    add(1, 0, Z);         add(1, 1, C1P);       add(1, 2, C1N);       add(1, 3, C2P);
    add(1, 4, C2N);       add(1, 5, C1P);       add(1, 15, C2P);      add(1, 16, C2N);
    add(1, 17, C1P | RB); add(1, 18, C1N | RB); add(1, 30, C1N | RB); add(1, 31, Z);
    add(1, 32, C1P);      add(1, 35, C2N);      add(1, 47, C2N);      add(1, 48, C1P | RB);
    // 2: DIV=3, one-cycle strobes and levels, RESETB after 4th CP2N at 46.
    add(2, 1, C1P);       add(2, 2, L1);        add(2, 3, L1);        add(2, 4, C1N);
    add(2, 5, Z);         add(2, 7, C2P);       add(2, 8, L2);        add(2, 9, L2);
    add(2, 10, C2N);      add(2, 11, Z);        add(2, 13, C1P);      add(2, 46, C2N);
    add(2, 47, RB);       add(2, 49, C1P | RB);
    // 3: DIV=1, HOLD raised mid T-state in cycle 6, dropped in cycle 20.
    add(3, 5, C1P);       add(3, 6, C1N);       add(3, 7, C2P);       add(3, 8, C2N);
    add(3, 9, HA);        add(3, 14, HA);       add(3, 19, HA);       add(3, 20, C1P);
    add(3, 21, C1N);      add(3, 23, C2N);      add(3, 27, C2N);      add(3, 28, C1P | RB);
    // 4: RST_TSTATES=2, frozen from the first cycle for 10 cycles.
    add(4, 0, Z);         add(4, 1, HA);        add(4, 10, HA);       add(4, 11, C1P);
    add(4, 12, C1N);      add(4, 14, C2N);      add(4, 15, C1P);      add(4, 18, C2N);
    add(4, 19, C1P | RB);
    // 5: RESET while frozen wins over HOLD, then freezes again.
    add(5, 1, HA);        add(5, 5, HA);        add(5, 6, Z);         add(5, 7, HA);
    add(5, 8, HA);
    // 6: DIV=16, 64-cycle T-state and counter wrap.
    add(6, 1, C1P);       add(6, 2, L1);        add(6, 16, L1);       add(6, 17, C1N);
    add(6, 18, Z);        add(6, 33, C2P);      add(6, 48, L2);       add(6, 49, C2N);
    add(6, 50, Z);        add(6, 64, Z);        add(6, 65, C1P);      add(6, 66, L1);

    run_scn(1, 0, 49, -1, -2, 30);
    run_scn(2, 1, 49, -1, -2, -1);
    run_scn(3, 0, 30,  6, 19, -1);
    run_scn(4, 2, 20,  1, 10, -1);
    run_scn(5, 2,  8,  1, 40,  5);
    run_scn(6, 3, 66, -1, -2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
